// File: rtl/riscv_dmem_arb_if.sv
// riscv_dmem_arb_if
//   Bundles every signal between riscv_dmem_arb and its neighbours: the LSU
//   (port 0), the program/data loader (port 1) and the single-ported
//   riscv_dmem.
//   Port summary:
//     i_p{0,1}_req/wr_en/addr/byte_sel/data : request fields from each port
//     i_p1_len                              : burst beats minus 1 (port 1)
//     o_p{0,1}_gnt/rvalid/rdata             : grant and read return per port
//     o_p1_busy                             : port 1 burst in progress
//     o_dmem_wr_en/data/addr/byte_sel       : memory-side request
//     i_dmem_data                           : memory read data (combinational)
//   Modports: slave is the arbiter's view; master is the view of everything
//   around it (requesters and the memory).
interface riscv_dmem_arb_if #(
   parameter int XLEN          = 32,
   parameter int DMEM_ADDR_BIT = 12,
   parameter int LEN_BIT       = 8
);
   logic                       i_p0_req;
   logic                       i_p0_wr_en;
   logic [DMEM_ADDR_BIT-1:0]   i_p0_addr;
   logic [XLEN/8-1:0]          i_p0_byte_sel;
   logic [XLEN-1:0]            i_p0_data;
   logic                       o_p0_gnt;
   logic                       o_p0_rvalid;
   logic [XLEN-1:0]            o_p0_rdata;

   logic                       i_p1_req;
   logic                       i_p1_wr_en;
   logic [DMEM_ADDR_BIT-1:0]   i_p1_addr;
   logic [XLEN/8-1:0]          i_p1_byte_sel;
   logic [XLEN-1:0]            i_p1_data;
   logic [LEN_BIT-1:0]         i_p1_len;
   logic                       o_p1_gnt;
   logic                       o_p1_rvalid;
   logic [XLEN-1:0]            o_p1_rdata;
   logic                       o_p1_busy;

   logic                       o_dmem_wr_en;
   logic [XLEN-1:0]            o_dmem_data;
   logic [DMEM_ADDR_BIT-3:0]   o_dmem_addr;
   logic [XLEN/8-1:0]          o_dmem_byte_sel;
   logic [XLEN-1:0]            i_dmem_data;

   modport slave (
      input  i_p0_req, i_p0_wr_en, i_p0_addr, i_p0_byte_sel, i_p0_data,
      output o_p0_gnt, o_p0_rvalid, o_p0_rdata,
      input  i_p1_req, i_p1_wr_en, i_p1_addr, i_p1_byte_sel, i_p1_data, i_p1_len,
      output o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_busy,
      output o_dmem_wr_en, o_dmem_data, o_dmem_addr, o_dmem_byte_sel,
      input  i_dmem_data
   );

   modport master (
      output i_p0_req, i_p0_wr_en, i_p0_addr, i_p0_byte_sel, i_p0_data,
      input  o_p0_gnt, o_p0_rvalid, o_p0_rdata,
      output i_p1_req, i_p1_wr_en, i_p1_addr, i_p1_byte_sel, i_p1_data, i_p1_len,
      input  o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_busy,
      input  o_dmem_wr_en, o_dmem_data, o_dmem_addr, o_dmem_byte_sel,
      output i_dmem_data
   );
endinterface

// File: rtl/riscv_dmem_arb.sv
// riscv_dmem_arb
//   Shares the single-ported riscv_dmem between the core LSU (port 0) and a
//   loader (port 1). Idle arbitration is round-robin on ties; port 1 can lock
//   the memory for a multi-beat burst with an auto-incrementing word address.
//   Byte addresses are reduced to word addresses; read data is registered
//   back to the port that issued the read, one cycle after its grant.
//   Ports:
//     i_clk  : clock, rising edge
//     i_rstn : asynchronous active-low reset
//     bus    : riscv_dmem_arb_if.slave (both requester ports + memory side)
module riscv_dmem_arb #(
   parameter int XLEN          = 32,
   parameter int DMEM_ADDR_BIT = 12,
   parameter int LEN_BIT       = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   riscv_dmem_arb_if.slave       bus
);

   localparam int WA_W  = DMEM_ADDR_BIT - 2;
   localparam int SEL_W = XLEN / 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t              state;
   logic                last;
   logic [LEN_BIT-1:0]  beat_cnt;
   logic [WA_W-1:0]     b_addr;
   logic                b_wr;
   logic [SEL_W-1:0]    b_sel;
   logic                busy;

   logic                p0_rvalid;
   logic [XLEN-1:0]     p0_rdata;
   logic                p1_rvalid;
   logic [XLEN-1:0]     p1_rdata;

   logic                p0_gnt;
   logic                p1_gnt;
   logic                p1_wr;
   logic [WA_W-1:0]     p1_waddr;
   logic [SEL_W-1:0]    p1_sel;

   // Byte-offset bits are dropped on purpose: no misalignment trap here.
   logic [3:0]          unused_addr_lsb;
   assign unused_addr_lsb = {bus.i_p0_addr[1:0], bus.i_p1_addr[1:0]};

   // Port 1 effective fields: inside a burst the latched values win.
   always_comb begin
      p1_wr    = bus.i_p1_wr_en;
      p1_waddr = bus.i_p1_addr[DMEM_ADDR_BIT-1:2];
      p1_sel   = bus.i_p1_byte_sel;
      if (state == BURST) begin
         p1_wr    = b_wr;
         p1_waddr = b_addr;
         p1_sel   = b_sel;
      end
   end

   // Grants are gated by reset so the memory sees no write while i_rstn is
   // low, even if a requester keeps asserting req.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (i_rstn) begin
         if (state == BURST) begin
            p1_gnt = bus.i_p1_req;
         end else begin
            // On a tie the port that was not granted last wins.
            p0_gnt = bus.i_p0_req & (~bus.i_p1_req | last);
            p1_gnt = bus.i_p1_req & (~bus.i_p0_req | ~last);
         end
      end
   end

   always_comb begin
      bus.o_dmem_wr_en    = 1'b0;
      bus.o_dmem_data     = '0;
      bus.o_dmem_addr     = '0;
      bus.o_dmem_byte_sel = '0;
      if (p0_gnt) begin
         bus.o_dmem_wr_en    = bus.i_p0_wr_en;
         bus.o_dmem_data     = bus.i_p0_data;
         bus.o_dmem_addr     = bus.i_p0_addr[DMEM_ADDR_BIT-1:2];
         bus.o_dmem_byte_sel = bus.i_p0_byte_sel;
      end else if (p1_gnt) begin
         bus.o_dmem_wr_en    = p1_wr;
         bus.o_dmem_data     = bus.i_p1_data;
         bus.o_dmem_addr     = p1_waddr;
         bus.o_dmem_byte_sel = p1_sel;
      end
   end

   // Grant edge -> read return stage
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         p0_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rvalid <= 1'b0;
         p1_rdata  <= '0;
      end else begin
         p0_rvalid <= p0_gnt & ~bus.i_p0_wr_en;
         p1_rvalid <= p1_gnt & ~p1_wr;
         if (p0_gnt && !bus.i_p0_wr_en) p0_rdata <= bus.i_dmem_data;
         if (p1_gnt && !p1_wr)          p1_rdata <= bus.i_dmem_data;
      end
   end

   // Arbitration / burst FSM
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state    <= IDLE;
         last     <= 1'b1;
         beat_cnt <= '0;
         b_addr   <= '0;
         b_wr     <= 1'b0;
         b_sel    <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (p0_gnt) begin
                  last <= 1'b0;
               end else if (p1_gnt) begin
                  last <= 1'b1;
                  // The first beat happens now; beat_cnt counts what remains.
                  if (bus.i_p1_len != '0) begin
                     beat_cnt <= bus.i_p1_len;
                     b_addr   <= bus.i_p1_addr[DMEM_ADDR_BIT-1:2] + WA_W'(1);
                     b_wr     <= bus.i_p1_wr_en;
                     b_sel    <= bus.i_p1_byte_sel;
                     state    <= BURST;
                     busy     <= 1'b1;
                  end
               end
            end
            BURST: begin
               // A dropped req is a stall: nothing moves.
               if (p1_gnt) begin
                  b_addr   <= b_addr + WA_W'(1);
                  beat_cnt <= beat_cnt - LEN_BIT'(1);
                  if (beat_cnt == LEN_BIT'(1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     last  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_p0_gnt    = p0_gnt;
   assign bus.o_p1_gnt    = p1_gnt;
   assign bus.o_p0_rvalid = p0_rvalid;
   assign bus.o_p0_rdata  = p0_rdata;
   assign bus.o_p1_rvalid = p1_rvalid;
   assign bus.o_p1_rdata  = p1_rdata;
   assign bus.o_p1_busy   = busy;

endmodule

// File: tb/tb_riscv_dmem_arb.sv
module tb_riscv_dmem_arb;

   logic clk;
   logic rstn;
   int   total;
   int   bad;

   riscv_dmem_arb_if bus ();

   riscv_dmem_arb dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for riscv_dmem: combinational read, byte-lane write on the edge.
   logic [31:0] mem [0:1023];
   assign bus.i_dmem_data = mem[bus.o_dmem_addr];

   always @(posedge clk) begin
      if (bus.o_dmem_wr_en) begin
         for (int b = 0; b < 4; b++)
            if (bus.o_dmem_byte_sel[b])
               mem[bus.o_dmem_addr][8*b +: 8] = bus.o_dmem_data[8*b +: 8];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.i_p0_req = 0; bus.i_p0_wr_en = 0; bus.i_p0_addr = '0;
      bus.i_p0_byte_sel = '0; bus.i_p0_data = '0;
      bus.i_p1_req = 0; bus.i_p1_wr_en = 0; bus.i_p1_addr = '0;
      bus.i_p1_byte_sel = '0; bus.i_p1_data = '0; bus.i_p1_len = '0;
   endtask

   // Drives one port 0 read and returns what comes back the cycle after.
   task automatic p0_read(input logic [11:0] addr, output logic rv, output logic [31:0] rd);
      bus.i_p0_req = 1; bus.i_p0_wr_en = 0; bus.i_p0_addr = addr;
      bus.i_p0_byte_sel = 4'hF;
      #1;
      tick();
      rv = bus.o_p0_rvalid;
      rd = bus.o_p0_rdata;
      bus.i_p0_req = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rstn = 0;
      bus.i_p1_req = 1; bus.i_p1_wr_en = 1; bus.i_p1_byte_sel = 4'hF;
      #3;
      total++; if (bus.o_dmem_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.o_dmem_wr_en); end
      total++; if (bus.o_p1_gnt !== 1'b0) begin bad++; $display("FAIL reset_p1_gnt got=%b exp=0", bus.o_p1_gnt); end
      total++; if ({bus.o_p0_rvalid, bus.o_p1_rvalid, bus.o_p1_busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus.o_p0_rvalid, bus.o_p1_rvalid, bus.o_p1_busy}); end
      total++; if (bus.o_p0_rdata !== 32'h0 || bus.o_p1_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.o_p0_rdata, bus.o_p1_rdata); end
      tick();
      idle_inputs();
      #1;
      rstn = 1;
      tick();
   endtask

   task automatic test_single;
      bus.i_p0_req = 1; bus.i_p0_wr_en = 1; bus.i_p0_addr = 12'h010;
      bus.i_p0_byte_sel = 4'hF; bus.i_p0_data = 32'hDEADBEEF;
      #1;
      total++; if (bus.o_p0_gnt !== 1'b1 || bus.o_dmem_addr !== 10'd4 || bus.o_dmem_wr_en !== 1'b1) begin bad++; $display("FAIL single_wr gnt=%b addr=%0d we=%b exp 1/4/1", bus.o_p0_gnt, bus.o_dmem_addr, bus.o_dmem_wr_en); end
      total++; if (bus.o_dmem_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", bus.o_dmem_data); end
      tick();
      total++; if (bus.o_p0_rvalid !== 1'b0) begin bad++; $display("FAIL single_wr_rvalid got=%b exp=0", bus.o_p0_rvalid); end
      bus.i_p0_wr_en = 0;
      #1;
      total++; if (bus.o_p0_gnt !== 1'b1 || bus.o_dmem_addr !== 10'd4 || bus.o_dmem_wr_en !== 1'b0) begin bad++; $display("FAIL single_rd gnt=%b addr=%0d we=%b exp 1/4/0", bus.o_p0_gnt, bus.o_dmem_addr, bus.o_dmem_wr_en); end
      tick();
      bus.i_p0_req = 0;
      total++; if (bus.o_p0_rvalid !== 1'b1 || bus.o_p0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata rv=%b got=%h exp 1/deadbeef", bus.o_p0_rvalid, bus.o_p0_rdata); end
      #1;
      total++; if (bus.o_dmem_addr !== 10'd0 || bus.o_dmem_wr_en !== 1'b0) begin bad++; $display("FAIL idle_mux addr=%0d we=%b exp 0/0", bus.o_dmem_addr, bus.o_dmem_wr_en); end
      tick();
      total++; if (bus.o_p0_rvalid !== 1'b0 || bus.o_p0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_pulse rv=%b rd=%h exp 0/deadbeef", bus.o_p0_rvalid, bus.o_p0_rdata); end
   endtask

   task automatic test_round_robin;
      logic e0;
      idle_inputs();
      rstn = 0; #2; rstn = 1;
      tick();
      bus.i_p0_req = 1; bus.i_p0_addr = 12'h014;
      bus.i_p1_req = 1; bus.i_p1_addr = 12'h018; bus.i_p1_len = 8'd0;
      for (int k = 0; k < 4; k++) begin
         e0 = (k % 2 == 0);
         #1;
         total++; if (bus.o_p0_gnt !== e0 || bus.o_p1_gnt !== ~e0) begin bad++; $display("FAIL rr_gnt k=%0d got=%b%b exp=%b%b", k, bus.o_p0_gnt, bus.o_p1_gnt, e0, ~e0); end
         tick();
         total++; if (bus.o_p0_rvalid !== e0 || bus.o_p1_rvalid !== ~e0) begin bad++; $display("FAIL rr_rvalid k=%0d got=%b%b exp=%b%b", k, bus.o_p0_rvalid, bus.o_p1_rvalid, e0, ~e0); end
         if (e0) begin
            total++; if (bus.o_p0_rdata !== 32'hC0DE0005) begin bad++; $display("FAIL rr_p0_rdata got=%h exp=c0de0005", bus.o_p0_rdata); end
         end else begin
            total++; if (bus.o_p1_rdata !== 32'hC0DE0006) begin bad++; $display("FAIL rr_p1_rdata got=%h exp=c0de0006", bus.o_p1_rdata); end
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_burst_write;
      logic        rv;
      logic [31:0] rd;
      bus.i_p0_req = 1; bus.i_p0_wr_en = 0; bus.i_p0_addr = 12'h014;
      #1;
      total++; if (bus.o_p0_gnt !== 1'b1) begin bad++; $display("FAIL bw_pre_gnt got=%b exp=1", bus.o_p0_gnt); end
      tick();
      bus.i_p1_req = 1; bus.i_p1_wr_en = 1; bus.i_p1_addr = 12'h020; bus.i_p1_len = 8'd3;
      bus.i_p1_byte_sel = 4'hF; bus.i_p1_data = 32'd1;
      #1;
      total++; if (bus.o_p1_gnt !== 1'b1 || bus.o_p0_gnt !== 1'b0 || bus.o_dmem_addr !== 10'd8 || bus.o_dmem_wr_en !== 1'b1 || bus.o_p1_busy !== 1'b0) begin bad++; $display("FAIL bw_beat1 g1=%b g0=%b addr=%0d we=%b busy=%b exp 1/0/8/1/0", bus.o_p1_gnt, bus.o_p0_gnt, bus.o_dmem_addr, bus.o_dmem_wr_en, bus.o_p1_busy); end
      tick();
      for (int beat = 2; beat <= 4; beat++) begin
         bus.i_p1_data = 32'(beat); bus.i_p1_addr = 12'h300; bus.i_p1_len = 8'd0;
         #1;
         total++; if (bus.o_p1_gnt !== 1'b1 || bus.o_p0_gnt !== 1'b0 || bus.o_dmem_addr !== 10'(7 + beat) || bus.o_dmem_wr_en !== 1'b1 || bus.o_dmem_data !== 32'(beat) || bus.o_p1_busy !== 1'b1) begin bad++; $display("FAIL bw_beat%0d g1=%b g0=%b addr=%0d we=%b d=%0d busy=%b", beat, bus.o_p1_gnt, bus.o_p0_gnt, bus.o_dmem_addr, bus.o_dmem_wr_en, bus.o_dmem_data, bus.o_p1_busy); end
         tick();
      end
      total++; if (bus.o_p1_busy !== 1'b0) begin bad++; $display("FAIL bw_busy_fall got=%b exp=0", bus.o_p1_busy); end
      bus.i_p1_wr_en = 0; bus.i_p1_addr = 12'h020;
      #1;
      total++; if (bus.o_p0_gnt !== 1'b1 || bus.o_p1_gnt !== 1'b0) begin bad++; $display("FAIL bw_p0_after got=%b%b exp=10", bus.o_p0_gnt, bus.o_p1_gnt); end
      tick();
      total++; if (bus.o_p0_rvalid !== 1'b1 || bus.o_p0_rdata !== 32'hC0DE0005) begin bad++; $display("FAIL bw_p0_rd rv=%b rd=%h exp 1/c0de0005", bus.o_p0_rvalid, bus.o_p0_rdata); end
      bus.i_p0_req = 0;
      #1;
      total++; if (bus.o_p1_gnt !== 1'b1 || bus.o_dmem_addr !== 10'd8) begin bad++; $display("FAIL bw_p1_rd_gnt g=%b addr=%0d exp 1/8", bus.o_p1_gnt, bus.o_dmem_addr); end
      tick();
      bus.i_p1_req = 0;
      total++; if (bus.o_p1_rvalid !== 1'b1 || bus.o_p1_rdata !== 32'd1) begin bad++; $display("FAIL bw_word8 rv=%b rd=%h exp 1/1", bus.o_p1_rvalid, bus.o_p1_rdata); end
      for (int w = 9; w <= 11; w++) begin
         p0_read(12'(w * 4), rv, rd);
         total++; if (rv !== 1'b1 || rd !== 32'(w - 7)) begin bad++; $display("FAIL bw_word%0d rv=%b rd=%h exp 1/%0d", w, rv, rd, w - 7); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_stall_wrap;
      logic        rv;
      logic [31:0] rd;
      bus.i_p1_req = 1; bus.i_p1_wr_en = 1; bus.i_p1_addr = 12'hFFC; bus.i_p1_len = 8'd2;
      bus.i_p1_byte_sel = 4'hF; bus.i_p1_data = 32'hA1;
      #1;
      total++; if (bus.o_p1_gnt !== 1'b1 || bus.o_dmem_addr !== 10'd1023 || bus.o_dmem_wr_en !== 1'b1) begin bad++; $display("FAIL sw_beat1 g=%b addr=%0d we=%b exp 1/1023/1", bus.o_p1_gnt, bus.o_dmem_addr, bus.o_dmem_wr_en); end
      tick();
      bus.i_p1_req = 0;
      for (int s = 0; s < 2; s++) begin
         #1;
         total++; if (bus.o_p1_gnt !== 1'b0 || bus.o_dmem_wr_en !== 1'b0 || bus.o_p1_busy !== 1'b1) begin bad++; $display("FAIL sw_stall%0d g=%b we=%b busy=%b exp 0/0/1", s, bus.o_p1_gnt, bus.o_dmem_wr_en, bus.o_p1_busy); end
         tick();
      end
      bus.i_p1_req = 1; bus.i_p1_data = 32'hA2;
      #1;
      total++; if (bus.o_p1_gnt !== 1'b1 || bus.o_dmem_addr !== 10'd0 || bus.o_dmem_wr_en !== 1'b1) begin bad++; $display("FAIL sw_beat2 g=%b addr=%0d we=%b exp 1/0/1", bus.o_p1_gnt, bus.o_dmem_addr, bus.o_dmem_wr_en); end
      tick();
      bus.i_p1_data = 32'hA3;
      #1;
      total++; if (bus.o_p1_gnt !== 1'b1 || bus.o_dmem_addr !== 10'd1) begin bad++; $display("FAIL sw_beat3 g=%b addr=%0d exp 1/1", bus.o_p1_gnt, bus.o_dmem_addr); end
      tick();
      bus.i_p1_req = 0;
      total++; if (bus.o_p1_busy !== 1'b0) begin bad++; $display("FAIL sw_busy got=%b exp=0", bus.o_p1_busy); end
      p0_read(12'hFFC, rv, rd);
      total++; if (rd !== 32'hA1) begin bad++; $display("FAIL sw_w1023 got=%h exp=a1", rd); end
      p0_read(12'h000, rv, rd);
      total++; if (rd !== 32'hA2) begin bad++; $display("FAIL sw_w0 got=%h exp=a2", rd); end
      p0_read(12'h004, rv, rd);
      total++; if (rd !== 32'hA3) begin bad++; $display("FAIL sw_w1 got=%h exp=a3", rd); end
      idle_inputs();
      tick();
   endtask

   task automatic test_byte_lanes;
      logic        rv;
      logic [31:0] rd;
      bus.i_p0_req = 1; bus.i_p0_wr_en = 1; bus.i_p0_addr = 12'h000;
      bus.i_p0_byte_sel = 4'hF; bus.i_p0_data = 32'hFFFFFFFF;
      tick();
      bus.i_p0_byte_sel = 4'b0001; bus.i_p0_data = 32'h12345678;
      #1;
      total++; if (bus.o_dmem_byte_sel !== 4'b0001 || bus.o_dmem_wr_en !== 1'b1) begin bad++; $display("FAIL bl_sel got=%b we=%b exp 0001/1", bus.o_dmem_byte_sel, bus.o_dmem_wr_en); end
      tick();
      p0_read(12'h000, rv, rd);
      total++; if (rv !== 1'b1 || rd !== 32'hFFFFFF78) begin bad++; $display("FAIL bl_rdata rv=%b got=%h exp 1/ffffff78", rv, rd); end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_burst;
      logic        rv;
      logic [31:0] rd;
      logic [31:0] exp_w [0:4];
      exp_w[0] = 32'h50000001; exp_w[1] = 32'h50000002;
      exp_w[2] = 32'hC0DE0012; exp_w[3] = 32'hC0DE0013; exp_w[4] = 32'hC0DE0014;
      bus.i_p1_req = 1; bus.i_p1_wr_en = 1; bus.i_p1_addr = 12'h040; bus.i_p1_len = 8'd4;
      bus.i_p1_byte_sel = 4'hF; bus.i_p1_data = 32'h50000001;
      tick();
      bus.i_p1_data = 32'h50000002;
      tick();
      bus.i_p1_data = 32'h50000003;
      rstn = 0;
      #1;
      total++; if (bus.o_dmem_wr_en !== 1'b0 || bus.o_p1_busy !== 1'b0 || bus.o_p1_gnt !== 1'b0) begin bad++; $display("FAIL rmb_abort we=%b busy=%b g1=%b exp 0/0/0", bus.o_dmem_wr_en, bus.o_p1_busy, bus.o_p1_gnt); end
      tick();
      total++; if (bus.o_dmem_wr_en !== 1'b0) begin bad++; $display("FAIL rmb_held_we got=%b exp=0", bus.o_dmem_wr_en); end
      idle_inputs();
      rstn = 1;
      tick();
      bus.i_p0_req = 1; bus.i_p0_addr = 12'h040;
      bus.i_p1_req = 1; bus.i_p1_addr = 12'h044;
      #1;
      total++; if (bus.o_p0_gnt !== 1'b1 || bus.o_p1_gnt !== 1'b0) begin bad++; $display("FAIL rmb_tie got=%b%b exp=10", bus.o_p0_gnt, bus.o_p1_gnt); end
      tick();
      idle_inputs();
      for (int w = 0; w < 5; w++) begin
         p0_read(12'(12'h040 + w * 4), rv, rd);
         total++; if (rd !== exp_w[w]) begin bad++; $display("FAIL rmb_word%0d got=%h exp=%h", 16 + w, rd, exp_w[w]); end
      end
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      rstn = 0;
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_burst_write();
      test_stall_wrap();
      test_byte_lanes();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_dmem_arb.md
# riscv_dmem_arb

Two-port arbiter that shares the single-ported `riscv_dmem` between the core load/store unit (port 0) and a program/data loader (port 1). Port 1 may lock the memory for a multi-beat burst with an auto-incrementing address. The block converts byte addresses to the memory's word address and registers read data back to the port that issued the read. It sits between the LSU/loader and `riscv_dmem` in the RV32I core.

## Interface
- `XLEN`, 32, data width.
- `DMEM_ADDR_BIT`, 12, byte-address width. The memory word address is `DMEM_ADDR_BIT-2` bits.
- `LEN_BIT`, 8, width of the burst length field.

- `i_clk` in 1: single clock, rising edge.
- `i_rstn` in 1: asynchronous, active-low reset.
- `i_p0_req`, `i_p0_wr_en` in 1: port 0 request and write enable.
- `i_p0_addr` in `DMEM_ADDR_BIT`: port 0 byte address.
- `i_p0_byte_sel` in `XLEN/8`: port 0 byte lanes.
- `i_p0_data` in `XLEN`: port 0 write data.
- `o_p0_gnt` out 1: port 0 grant.
- `o_p0_rvalid` out 1: port 0 read data valid.
- `o_p0_rdata` out `XLEN`: port 0 read data.
- `i_p1_req`, `i_p1_wr_en`, `i_p1_addr`, `i_p1_byte_sel`, `i_p1_data`: port 1, same meaning as port 0.
- `i_p1_len` in `LEN_BIT`: burst beats minus 1. Sampled only on the first grant.
- `o_p1_gnt`, `o_p1_rvalid`, `o_p1_rdata`: port 1, same meaning as port 0.
- `o_p1_busy` out 1: burst in progress.
- `o_dmem_wr_en` out 1: memory write enable.
- `o_dmem_data` out `XLEN`: memory write data.
- `o_dmem_addr` out `DMEM_ADDR_BIT-2`: memory word address.
- `o_dmem_byte_sel` out `XLEN/8`: memory byte lanes.
- `i_dmem_data` in `XLEN`: memory read data. It is combinational from `o_dmem_addr`.

## Operation
**States and registers**
- FSM states: IDLE and BURST.
- Registers:
  - `last`: the last port granted in IDLE.
  - `beat_cnt`: `LEN_BIT` bits.
  - `b_addr`: word address.
  - `b_wr`, `b_sel`: latched burst write enable and byte lanes.

**Handshake**
- A requester holds `req` and its fields stable until it sees `gnt`.
- The transfer occurs on the rising edge where `gnt`=1.
- `gnt` is combinational from `req`, state and `last`. At most one `gnt` is high per cycle.

**IDLE arbitration**
- Only one port requesting: that port is granted.
- Both ports requesting: the port that is not `last` is granted (round-robin). `last` updates on every IDLE grant.

**IDLE port 1 grant with `i_p1_len`≠0**
- Latch `beat_cnt`=`i_p1_len`, `b_addr`=`i_p1_addr[DMEM_ADDR_BIT-1:2]`+1, `b_wr`, and `b_sel`.
- Go to BURST.
- With `i_p1_len`=0 the transfer is a single beat and the FSM stays in IDLE.

**BURST**
- `o_p0_gnt`=0.
- `o_p1_gnt`=`i_p1_req`. The address comes from `b_addr`; `i_p1_addr` and `i_p1_len` are ignored.
- Each granted beat: `b_addr`+=1, wrapping modulo 2^(`DMEM_ADDR_BIT`-2), and `beat_cnt`-=1.
- On the beat where `beat_cnt`=1 before decrement (the last beat), go to IDLE and set `last`=1.
- `i_p1_req`=0 in BURST is a stall: no transfer, and the counters hold.

**Memory-side mux**
- Granted port drives the memory. Word address is `addr[DMEM_ADDR_BIT-1:2]`; `addr[1:0]` is ignored (no misalignment trap).
- `o_dmem_wr_en` = `gnt & wr_en`.
- No grant: `o_dmem_wr_en`=0, and address, data and byte lanes are 0.

**Reads**
- On a read grant edge, `i_dmem_data` is captured into that port's `rdata`. That port's `rvalid` is high for exactly the next cycle.
- `rdata` holds until the port's next read.
- Writes never raise `rvalid`.

## Timing
- Reset (async assert, `i_rstn`=0):
  - FSM to IDLE, `last`=1, so port 0 wins the first tie.
  - `beat_cnt`=0, `b_addr`=0.
  - `o_p0_rvalid`=`o_p1_rvalid`=0, both `rdata`=0, `o_p1_busy`=0.
  - `o_dmem_wr_en`=0 immediately.
- Reset mid-burst aborts the burst. No further writes occur; the remaining beats are lost.
- Latency:
  - Grant: 0 cycles.
  - Write commit: at the grant edge.
  - Read data: 1 cycle after the grant edge.
- Burst throughput: one beat per cycle. A burst of N beats occupies N consecutive grant cycles if `i_p1_req` stays high.
- `o_p1_busy` is 1 exactly while in BURST. It falls in the cycle after the last-beat edge.
- Simultaneous port 0 request at the burst end: port 0 is granted in the first IDLE cycle, because `last`=1.

## Test plan
- **Reset and single write/read:** reset, then port 0 writes 0xDEADBEEF at 0x010 with sel 4'b1111, then reads 0x010. Expect `o_dmem_addr`=4 during both transfers. `o_p0_rvalid` pulses 1 cycle after the read grant with `o_p0_rdata`=0xDEADBEEF.
- **Tie round-robin:** both ports request reads every cycle with `i_p1_len`=0. Expect grants p0, p1, p0, p1 starting with p0 after reset, and each `rvalid` only on the owning port.
- **Burst write:** port 1 writes `i_p1_len`=3 from 0x020 with data 1,2,3,4 while port 0 requests continuously.
  - Word addresses 8, 9, 10, 11 are written on 4 consecutive edges, and `o_p0_gnt`=0 throughout.
  - Port 0 is granted the cycle after `o_p1_busy` falls.
  - Reading back words 8-11 returns 1, 2, 3, 4.
- **Burst stall and wrap:** with `DMEM_ADDR_BIT`=12, port 1 bursts `i_p1_len`=2 from 0xFFC and drops `i_p1_req` for 2 cycles after beat 1. Expect addresses 1023, 0, 1, the counters held during the stall, and no write on stall cycles.
- **Byte lanes:** word 0 is 0xFFFFFFFF. Port 0 writes sel 4'b0001 with data 0x12345678, then reads. Expect `o_dmem_byte_sel`=4'b0001 on the write, and read data 0xFFFFFF78.
- **Reset mid-burst:** assert `i_rstn`=0 after beat 2 of a 5-beat write. Expect `o_dmem_wr_en`=0 immediately, `o_p1_busy`=0, beats 3-5 never written, and a port 0 tie won first after release.
